// File: rtl/univ_shift_reg_pkg.sv
// rtl/univ_shift_reg_pkg.sv - opcodes, states and helpers for univ_shift_reg (honours UNIV_SHIFT_REG_ROTATE_EN)
package univ_shift_reg_pkg;

   typedef enum logic [2:0] {
      OP_HOLD = 3'd0,
      OP_LOAD = 3'd1,
      OP_SHL  = 3'd2,
      OP_SHR  = 3'd3,
      OP_ASR  = 3'd4,
      OP_ROL  = 3'd5,
      OP_ROR  = 3'd6,
      OP_RSVD = 3'd7
   } op_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

   localparam logic [2:0] OP_RESERVED = 3'd7;

   // True for opcodes that run through the multi-step RUN state
   function automatic logic is_step_op(input op_e o);
      logic r;
      case (o)
         OP_SHL, OP_SHR, OP_ASR: r = 1'b1;
`ifdef UNIV_SHIFT_REG_ROTATE_EN
         OP_ROL, OP_ROR:         r = 1'b1;
`endif
         default:                r = 1'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/univ_shift_reg_usr_step.sv
// rtl/univ_shift_reg_usr_step.sv - single-step next-value function usr_step (rotates under UNIV_SHIFT_REG_ROTATE_EN)
module usr_step
   import univ_shift_reg_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] q,
   input  op_e              op,
   input  logic             sin_lsb,
   input  logic             sin_msb,
   output logic [WIDTH-1:0] q_next,
   output logic             sout_next
);

   // One shift/rotate step; non-step opcodes pass q through
   always_comb begin
      q_next    = q;
      sout_next = 1'b0;
      case (op)
         OP_SHL: begin
            q_next    = {q[WIDTH-2:0], sin_lsb};
            sout_next = q[WIDTH-1];
         end
         OP_SHR: begin
            q_next    = {sin_msb, q[WIDTH-1:1]};
            sout_next = q[0];
         end
         OP_ASR: begin
            q_next    = {q[WIDTH-1], q[WIDTH-1:1]};
            sout_next = q[0];
         end
`ifdef UNIV_SHIFT_REG_ROTATE_EN
         OP_ROL: begin
            q_next    = {q[WIDTH-2:0], q[WIDTH-1]};
            sout_next = q[WIDTH-1];
         end
         OP_ROR: begin
            q_next    = {q[0], q[WIDTH-1:1]};
            sout_next = q[0];
         end
`endif
         default: begin
            q_next    = q;
            sout_next = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/univ_shift_reg.sv
// rtl/univ_shift_reg.sv - universal shift register with start/busy/done handshake (rotates under UNIV_SHIFT_REG_ROTATE_EN)
module univ_shift_reg
   import univ_shift_reg_pkg::*;
#(
   parameter  int WIDTH = 8,
   localparam int CW    = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [CW-1:0]    cnt,
   input  logic [WIDTH-1:0] pdata,
   input  logic             sin_lsb,
   input  logic             sin_msb,
   output logic [WIDTH-1:0] q,
   output logic             sout,
   output logic             busy,
   output logic             done
);

   state_e            state;
   op_e               op_r;
   logic [CW-1:0]     remaining;
   logic [WIDTH-1:0]  step_q;
   logic              step_sout;
   op_e               op_in;
   logic [CW-1:0]     cnt_sat;

   assign op_in   = op_e'(op);
   assign cnt_sat = (cnt > CW'(WIDTH)) ? CW'(WIDTH) : cnt;

   usr_step #(.WIDTH(WIDTH)) u_step (
      .q         (q),
      .op        (op_r),
      .sin_lsb   (sin_lsb),
      .sin_msb   (sin_msb),
      .q_next    (step_q),
      .sout_next (step_sout)
   );

   // Command FSM: accept in IDLE, step once per edge in RUN, pulse done on completion
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= ST_IDLE;
         op_r      <= OP_HOLD;
         remaining <= '0;
         q         <= '0;
         sout      <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  if (op_in == OP_LOAD) begin
                     q    <= pdata;
                     done <= 1'b1;
                  end else if (is_step_op(op_in) && (cnt != '0)) begin
                     op_r      <= op_in;
                     remaining <= cnt_sat;
                     busy      <= 1'b1;
                     state     <= ST_RUN;
                  end else begin
                     // HOLD, reserved and zero-count commands just acknowledge
                     done <= 1'b1;
                  end
               end
            end
            ST_RUN: begin
               q         <= step_q;
               sout      <= step_sout;
               remaining <= remaining - 1'b1;
               if (remaining == CW'(1)) begin
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_univ_shift_reg.sv
// tb/tb_univ_shift_reg.sv - self-checking bench for univ_shift_reg (expectations follow UNIV_SHIFT_REG_ROTATE_EN)
module tb_univ_shift_reg;

   logic       clk;
   logic       reset;
   logic       start;
   logic [2:0] op;
   logic [3:0] cnt;
   logic [7:0] pdata;
   logic       sin_lsb;
   logic       sin_msb;
   logic [7:0] q;
   logic       sout;
   logic       busy;
   logic       done;

   int total = 0;
   int bad   = 0;

   logic [7:0] mq;
   logic       ms;
   logic [7:0] tr[$];

   univ_shift_reg #(.WIDTH(8)) dut (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .op      (op),
      .cnt     (cnt),
      .pdata   (pdata),
      .sin_lsb (sin_lsb),
      .sin_msb (sin_msb),
      .q       (q),
      .sout    (sout),
      .busy    (busy),
      .done    (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Whole-command reference: applies n = min(cnt, 8) steps in closed form
   function automatic int model(input int o, input int c, input logic [7:0] pd,
                                input logic sl, input logic sm);
      int n;
      logic [15:0] w;
      bit rot;
      n = (c > 8) ? 8 : c;
`ifdef UNIV_SHIFT_REG_ROTATE_EN
      rot = 1'b1;
`else
      rot = 1'b0;
`endif
      if (o == 1) begin
         mq = pd;
         return 0;
      end
      if (n == 0 || o == 0 || o == 7 || ((o == 5 || o == 6) && !rot)) return 0;
      case (o)
         2: begin
            ms = mq[8-n];
            w  = {8'h00, mq} << n;
            if (sl) w = w | ((16'h1 << n) - 16'h1);
            mq = w[7:0];
         end
         3: begin
            ms = mq[n-1];
            w  = {mq, 8'h00} >> n;
            if (sm) w = w | ~(16'hFFFF >> n);
            mq = w[15:8];
         end
         4: begin
            ms = mq[n-1];
            mq = 8'($signed(mq) >>> n);
         end
         5: begin
            ms = mq[8-n];
            w  = {mq, mq} << n;
            mq = w[15:8];
         end
         default: begin
            ms = mq[n-1];
            w  = {mq, mq} >> n;
            mq = w[7:0];
         end
      endcase
      return n;
   endfunction

   // Issue a command at the current negedge; return at the negedge of its done cycle
   task automatic cmd(input string tag, input int o, input int c, input logic [7:0] pd,
                      input logic sl, input logic sm, input bit noisy);
      int steps;
      int k;
      int busyc;
      bit seen;
      steps   = model(o, c, pd, sl, sm);
      start   = 1'b1;
      op      = 3'(o);
      cnt     = 4'(c);
      pdata   = pd;
      sin_lsb = sl;
      sin_msb = sm;
      @(negedge clk);
      start = 1'b0;
      tr.delete();
      busyc = 0;
      seen  = 1'b0;
      for (k = 1; k <= 40; k++) begin
         tr.push_back(q);
         check({tag, "_overlap"}, {31'd0, busy & done}, 32'd0);
         if (done) begin
            seen = 1'b1;
            break;
         end
         if (busy) busyc++;
         if (noisy) begin
            start = 1'($urandom);
            op    = 3'($urandom);
            cnt   = 4'($urandom);
            pdata = 8'($urandom);
         end
         @(negedge clk);
      end
      start = 1'b0;
      check({tag, "_done_seen"}, {31'd0, seen}, 32'd1);
      check({tag, "_done_cycle"}, k, steps + 1);
      check({tag, "_busy_cycles"}, busyc, steps);
      check({tag, "_q"}, {24'd0, q}, {24'd0, mq});
      check({tag, "_sout"}, {31'd0, sout}, {31'd0, ms});
   endtask

   initial begin
      reset   = 1'b1;
      start   = 1'b0;
      op      = 3'd0;
      cnt     = 4'd0;
      pdata   = 8'd0;
      sin_lsb = 1'b0;
      sin_msb = 1'b0;
      mq      = 8'd0;
      ms      = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_q", {24'd0, q}, 32'd0);
      check("rst_sout", {31'd0, sout}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      reset = 1'b0;
      @(negedge clk);

      cmd("load_a5", 1, 0, 8'hA5, 1'b0, 1'b0, 1'b0);
      check("load_a5_const", {24'd0, q}, 32'hA5);
      @(negedge clk);
      check("done_one_cycle", {31'd0, done}, 32'd0);

      cmd("shl3", 2, 3, 8'h00, 1'b1, 1'b0, 1'b0);
      check("shl3_t1", {24'd0, tr[1]}, 32'h4B);
      check("shl3_t2", {24'd0, tr[2]}, 32'h97);
      check("shl3_t3", {24'd0, tr[3]}, 32'h2F);
      check("shl3_sout_const", {31'd0, sout}, 32'd1);
      @(negedge clk);

      cmd("load_90", 1, 0, 8'h90, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      cmd("asr2", 4, 2, 8'h00, 1'b0, 1'b0, 1'b0);
      check("asr2_const", {24'd0, q}, 32'hE4);
      cmd("b2b_load_3c", 1, 0, 8'h3C, 1'b0, 1'b0, 1'b0);
      cmd("ror8", 6, 8, 8'h00, 1'b0, 1'b0, 1'b0);
      check("ror8_const", {24'd0, q}, 32'h3C);
      @(negedge clk);

      cmd("load_c3", 1, 0, 8'hC3, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      start = 1'b1; op = 3'd3; cnt = 4'd5; sin_msb = 1'b0;
      @(negedge clk);
      check("rstrun_busy1", {31'd0, busy}, 32'd1);
      start = 1'b1; op = 3'd1; pdata = 8'h00;
      @(negedge clk);
      start = 1'b0;
      check("rstrun_load_ignored", {24'd0, q}, 32'h61);
      check("rstrun_busy2", {31'd0, busy}, 32'd1);
      @(negedge clk);
      reset = 1'b1;
      #1;
      check("rstrun_q", {24'd0, q}, 32'd0);
      check("rstrun_sout", {31'd0, sout}, 32'd0);
      check("rstrun_busy", {31'd0, busy}, 32'd0);
      check("rstrun_done", {31'd0, done}, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      mq = 8'd0;
      ms = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("rstrun_no_done", {31'd0, done}, 32'd0);
      end

      cmd("load_55", 1, 0, 8'h55, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      cmd("shr0", 3, 0, 8'h00, 1'b0, 1'b1, 1'b0);
      check("shr0_const", {24'd0, q}, 32'h55);
      @(negedge clk);
      cmd("shr15", 3, 15, 8'h00, 1'b0, 1'b1, 1'b0);
      check("shr15_const", {24'd0, q}, 32'hFF);

      for (int i = 0; i < 60; i++) begin
         cmd("rand", $urandom_range(0, 7), $urandom_range(0, 15), 8'($urandom),
             1'($urandom), 1'($urandom), 1'b1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/univ_shift_reg.md
# univ_shift_reg

Parametrised universal shift register: WIDTH-bit register with parallel load, logical/arithmetic shifts and optional rotates, executing multi-step shift commands under a start/busy/done handshake. Successor to the team's fixed 4-bit bidirectional serial shifter. Used wherever a datapath needs a bounded multi-bit shift or serialisation without an external counter.

## Interface
- WIDTH, default 8: register width, ≥ 2.
- CW, default $clog2(WIDTH+1): width of cnt, derived, not overridden.

- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high; clears all state.
- start  in  1  command strobe, sampled on clk edges while idle.
- op  in  3  opcode: 0 HOLD, 1 LOAD, 2 SHL, 3 SHR, 4 ASR, 5 ROL, 6 ROR, 7 reserved.
- cnt  in  CW  step count for shift/rotate ops, 0..WIDTH; values > WIDTH saturate to WIDTH.
- pdata  in  WIDTH  parallel load data.
- sin_lsb  in  1  serial bit entering q[0] on SHL.
- sin_msb  in  1  serial bit entering q[WIDTH-1] on SHR.
- q  out  WIDTH  register contents; reset 0.
- sout  out  1  last bit shifted/rotated out; reset 0.
- busy  out  1  multi-step command in progress; reset 0.
- done  out  1  one-cycle completion pulse; reset 0.

## Operation
- States IDLE, RUN. Reset → IDLE.
- IDLE, start=1 sampled at edge T0, op and cnt latched:
  - LOAD: q <= pdata at T0; done high for cycle after T0; stays IDLE.
  - HOLD, reserved op, or shift op with cnt=0: q, sout unchanged; done pulse after T0; stays IDLE.
  - Shift/rotate op with cnt≥1: remaining <= cnt; → RUN; busy high from T0.
- RUN: one step per edge T1..Tcnt, remaining decremented; at Tcnt → IDLE, busy low, done high for one cycle.
- Step definitions (left = toward MSB):
  - SHL: q <= {q[W-2:0], sin_lsb}; sout <= q[W-1].
  - SHR: q <= {sin_msb, q[W-1:1]}; sout <= q[0].
  - ASR: q <= {q[W-1], q[W-1:1]}; sout <= q[0].
  - ROL: q <= {q[W-2:0], q[W-1]}; sout <= q[W-1].
  - ROR: q <= {q[0], q[W-1:1]}; sout <= q[0].
- sin_lsb/sin_msb sampled live at each step edge, not latched.
- sout holds between steps and through LOAD/HOLD.
- start while busy=1 ignored; op/cnt changes during RUN ignored.
- Reset mid-RUN: q, sout, busy, done cleared immediately; no done pulse.

## Timing
- LOAD latency 1 edge; done visible cycle after T0.
- Shift of n steps: busy high n cycles, done in cycle n+1 after T0; total n+1 edges.
- start in the done cycle is accepted (back-to-back, no bubble).
- done and busy never high simultaneously.
- All outputs registered; no combinational input→output path.

## Configuration
- UNIV_SHIFT_REG_ROTATE_EN defined: ROL/ROR as above.
- Undefined: opcodes 5, 6 behave as reserved (HOLD semantics, done pulse after T0, no busy); rotate muxing not synthesised.

## Structure
- Package univ_shift_reg_pkg: opcode enum (OP_HOLD..OP_ROR), state enum (ST_IDLE, ST_RUN), helper constant for reserved opcode.
- One sub-module, usr_step: combinational next-value/sout function of (q, op, sin_lsb, sin_msb); top holds FSM, counter, registers.

## Test plan
- WIDTH=8. Reset, LOAD pdata=0xA5 → q=0xA5 after T0, done one cycle, busy never 1.
- From 0xA5, SHL cnt=3, sin_lsb=1 → q 0x4B, 0x97, 0x2F; sout=1; busy 3 cycles; done in 4th.
- From 0x90, ASR cnt=2 → q=0xE4, sout=0; second start issued in done cycle accepted.
- From 0x3C, ROR cnt=8 → q=0x3C, sout=0 with macro; without macro q unchanged, done after T0, busy 0.
- SHR cnt=5 started; start with LOAD during busy ignored; reset at step 2 → q=0, sout=0, busy=0, no done.
- SHR cnt=0 on 0x55 → q=0x55, sout unchanged, done pulse, busy 0; cnt=15 saturates to 8 steps.
